// File: rtl/pll_lock_sequencer.sv
// PLL start-up and supervision sequencer: pulses the PLL reset, qualifies LOCK,
// retries on timeout and holds downstream logic in reset until the clock is trusted.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 48,
    parameter int unsigned LOCK_FILTER  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 480000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] FILT_LAST = 16'(LOCK_FILTER - 1);
    localparam logic [23:0] TMO_LAST  = 24'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        sync1_q, lock_s_q;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] filt_cnt_q, filt_cnt_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  loss_q, loss_d;
    logic        pll_reset_q, sys_rst_q, ready_q, fault_q;
    logic        attempt_fail_s, retry_left_s;

    assign attempt_fail_s = (tmo_cnt_q == TMO_LAST);
    assign retry_left_s   = (retry_q < RETRY_MAX);

    // Next-state and counter update logic.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = 16'd0;
        filt_cnt_d = filt_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        retry_d    = retry_q;
        loss_d     = loss_q;
        case (state_q)
            S_RESET_PLL: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_WAIT_LOCK;
                    tmo_cnt_d = 24'd0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 16'd1;
                end
            end
            S_WAIT_LOCK: begin
                if (attempt_fail_s) begin
                    if (retry_left_s) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_RESET_PLL;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                    if (lock_s_q) begin
                        state_d    = S_FILTER;
                        filt_cnt_d = 16'd0;
                    end else begin
                        state_d = S_WAIT_LOCK;
                    end
                end
            end
            S_FILTER: begin
                // The timeout keeps running here so a chattering lock cannot stall forever.
                if (attempt_fail_s) begin
                    if (retry_left_s) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_RESET_PLL;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (filt_cnt_q == FILT_LAST) begin
                        state_d = S_RUN;
                        retry_d = 4'd0;
                    end else begin
                        filt_cnt_d = filt_cnt_q + 16'd1;
                    end
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end else begin
                        loss_d = loss_q;
                    end
                    state_d = S_RESET_PLL;
                end else if (relock_req) begin
                    state_d = S_RESET_PLL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FAULT: begin
                if (relock_req) begin
                    retry_d = 4'd0;
                    state_d = S_RESET_PLL;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase
    end

    // State, counters, synchronizer and registered outputs decoded from the next state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_RESET_PLL;
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            rst_cnt_q   <= 16'd0;
            filt_cnt_q  <= 16'd0;
            tmo_cnt_q   <= 24'd0;
            retry_q     <= 4'd0;
            loss_q      <= 8'd0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= pll_lock;
            lock_s_q    <= sync1_q;
            rst_cnt_q   <= rst_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= (state_d == S_RESET_PLL);
            sys_rst_q   <= (state_d != S_RUN);
            ready_q     <= (state_d == S_RUN);
            fault_q     <= (state_d == S_FAULT);
        end
    end

    assign pll_reset     = pll_reset_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus random lock activity,
// every cycle compared with a timestamp-based reference model.
module tb_pll_lock_sequencer;

    localparam int RST_C   = 4;
    localparam int FILT_C  = 8;
    localparam int TMO_C   = 64;
    localparam int RETRY_C = 2;

    localparam int M_RESET  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_FILTER = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAULT  = 4;

    logic       clkin      = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_lock   = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_reset, sys_rst, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: phase plus absolute edge deadlines
    int t = 0;
    int m_mode = M_RESET;
    int m_pulse_end = 0;
    int m_attempt_end = 0;
    int m_good = 0;
    int m_retry = 0;
    int m_loss = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    pll_lock_sequencer #(
        .RST_CYCLES  (RST_C),
        .LOCK_FILTER (FILT_C),
        .LOCK_TIMEOUT(TMO_C),
        .MAX_RETRY   (RETRY_C)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .relock_req   (relock_req),
        .pll_reset    (pll_reset),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d at edge %0d", tag, obs, exp, t);
        end
    endtask

    task automatic enter_reset();
        m_mode      = M_RESET;
        m_pulse_end = t + RST_C;
    endtask

    task automatic model_edge(input bit rst, input bit lk, input bit rq);
        bit lock_now;
        lock_now = m_s2;
        if (rst) begin
            m_retry = 0;
            m_loss  = 0;
            m_good  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            enter_reset();
        end else begin
            case (m_mode)
                M_RESET: begin
                    if (t == m_pulse_end) begin
                        m_mode        = M_WAIT;
                        m_attempt_end = t + TMO_C;
                    end
                end
                M_WAIT, M_FILTER: begin
                    if (t == m_attempt_end) begin
                        if (m_retry < RETRY_C) begin
                            m_retry++;
                            enter_reset();
                        end else begin
                            m_mode = M_FAULT;
                        end
                    end else if (m_mode == M_WAIT) begin
                        if (lock_now) begin
                            m_mode = M_FILTER;
                            m_good = 0;
                        end
                    end else if (!lock_now) begin
                        m_mode = M_WAIT;
                    end else begin
                        m_good++;
                        if (m_good == FILT_C) begin
                            m_mode  = M_RUN;
                            m_retry = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (!lock_now) begin
                        if (m_loss < 255) m_loss++;
                        enter_reset();
                    end else if (rq) begin
                        enter_reset();
                    end
                end
                default: begin
                    if (rq) begin
                        m_retry = 0;
                        enter_reset();
                    end
                end
            endcase
            m_s2 = m_s1;
            m_s1 = lk;
        end
    endtask

    task automatic step();
        @(posedge clkin);
        t++;
        model_edge(reset, pll_lock, relock_req);
        #1;
        check_eq("pll_reset", pll_reset, (m_mode == M_RESET));
        check_eq("sys_rst", sys_rst, (m_mode != M_RUN));
        check_eq("ready", ready, (m_mode == M_RUN));
        check_eq("fault", fault, (m_mode == M_FAULT));
        check_eq("retry_cnt", retry_cnt, m_retry);
        check_eq("lock_loss_cnt", lock_loss_cnt, m_loss);
        relock_req = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin
            step();
            n++;
        end
        if (!ready) check_eq("wait_ready_timeout", ready, 1);
    endtask

    initial begin
        int len;
        bit v;
        bit seen_ready;
        int n;

        reset = 1'b1;
        repeat (3) step();
        check_eq("rst_pll_reset", pll_reset, 1);
        check_eq("rst_sys_rst", sys_rst, 1);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_retry", retry_cnt, 0);
        check_eq("rst_loss", lock_loss_cnt, 0);

        // clean start, lock arrives at cycle 6
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            pll_lock = ((c - 1) >= 6);
            step();
            if (c <= 3) check_eq("start_pulse_hi", pll_reset, 1);
            if (c == 4) check_eq("start_pulse_lo", pll_reset, 0);
            if (c == 16) check_eq("start_not_ready", ready, 0);
            if (c == 17) begin
                check_eq("start_ready", ready, 1);
                check_eq("start_sys_rst", sys_rst, 0);
                check_eq("start_retry", retry_cnt, 0);
            end
        end

        // one-cycle lock drop in RUN
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        step();
        check_eq("drop_sys_rst", sys_rst, 1);
        check_eq("drop_ready", ready, 0);
        check_eq("drop_loss", lock_loss_cnt, 1);
        check_eq("drop_pll_reset", pll_reset, 1);
        wait_ready(100);
        check_eq("drop_relocked", ready, 1);

        // lock drop coincident with relock request
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        relock_req = 1'b1;
        step();
        check_eq("coinc_loss", lock_loss_cnt, 2);
        check_eq("coinc_pll_reset", pll_reset, 1);

        // saturation of the loss counter
        for (int k = 0; k < 300; k++) begin
            wait_ready(200);
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            step();
            step();
        end
        wait_ready(200);
        check_eq("loss_saturated", lock_loss_cnt, 255);

        // no lock at all: retries then FAULT
        pll_lock = 1'b0;
        n = 0;
        while (!fault && n < 1000) begin
            step();
            n++;
        end
        check_eq("fault_reached", fault, 1);
        check_eq("fault_sys_rst", sys_rst, 1);
        check_eq("fault_retry", retry_cnt, RETRY_C);
        check_eq("fault_pll_reset", pll_reset, 0);
        relock_req = 1'b1;
        step();
        check_eq("unfault_retry", retry_cnt, 0);
        check_eq("unfault_pll_reset", pll_reset, 1);
        check_eq("unfault_fault", fault, 0);

        // chattering lock never qualifies
        seen_ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            pll_lock = ((c / 5) % 2 == 1);
            step();
            if (ready) seen_ready = 1'b1;
            if (c == 67) check_eq("chatter_retry_before", retry_cnt, 0);
            if (c == 68) begin
                check_eq("chatter_retry_after", retry_cnt, 1);
                check_eq("chatter_pulse", pll_reset, 1);
            end
        end
        check_eq("chatter_never_ready", seen_ready, 0);

        // reset while in FILTER
        relock_req = 1'b1;
        pll_lock   = 1'b1;
        step();
        n = 0;
        while (m_mode != M_FILTER && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_pll_reset", pll_reset, 1);
        check_eq("midrst_sys_rst", sys_rst, 1);
        check_eq("midrst_retry", retry_cnt, 0);
        check_eq("midrst_loss", lock_loss_cnt, 0);
        check_eq("midrst_ready", ready, 0);

        // random lock activity, occasional relock requests and resets
        for (int s = 0; s < 250; s++) begin
            len = $urandom_range(1, 40);
            v   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                pll_lock   = v;
                relock_req = ($urandom_range(0, 29) == 0);
                reset      = ($urandom_range(0, 499) == 0);
                step();
            end
        end
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 48, sets the PLL reset pulse width in clkin cycles (1 us at 48 MHz); legal range 1..65535.
REQ-002 Parameter LOCK_FILTER, default 1024, sets the consecutive cycles of synchronized lock required before release; legal range 1..65535.
REQ-003 Parameter LOCK_TIMEOUT, default 480000, sets the cycles allowed per lock attempt (10 ms at 48 MHz); legal range 2..2^24-1.
REQ-004 Parameter MAX_RETRY, default 3, sets the re-attempts after the first timeout before fault; legal range 0..15.
REQ-005 clkin  input  1  sole clock; all logic is on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pll_lock  input  1  PLL LOCK, asynchronous to clkin.
REQ-008 relock_req  input  1  single-cycle request to restart the PLL; honoured in RUN and FAULT only.
REQ-009 pll_reset  output  1  drives the PLL RESET pin; active-high.
REQ-010 sys_rst  output  1  active-high reset for logic clocked from the PLL outputs.
REQ-011 ready  output  1  PLL locked and qualified (state RUN).
REQ-012 fault  output  1  retries exhausted (state FAULT).
REQ-013 retry_cnt  output  4  number of timeouts in the current sequence.
REQ-014 lock_loss_cnt  output  8  lock drops seen in RUN; saturates at 255.

Function
REQ-015 pll_lock shall pass through a 2-flop synchronizer giving lock_s, so state logic sees lock changes 2 cycles late.
REQ-016 All outputs shall be registered.
REQ-017 The FSM shall have the states RESET_PLL, WAIT_LOCK, FILTER, RUN and FAULT.
REQ-018 In RESET_PLL: pll_reset=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK, clear the timeout counter, and set pll_reset=0.
REQ-019 In WAIT_LOCK: lock_s=1 shall move to FILTER and clear the filter counter.
REQ-020 In FILTER: a lock_s=0 cycle shall return to WAIT_LOCK; after LOCK_FILTER consecutive lock_s=1 cycles, the FSM shall enter RUN.
REQ-021 The timeout counter shall run in both WAIT_LOCK and FILTER and be cleared only on entry from RESET_PLL, so a chattering lock still times out.
REQ-022 When the timeout counter reaches LOCK_TIMEOUT-1, the attempt shall fail (see REQ-023/REQ-024).
REQ-023 On failure with retry_cnt<MAX_RETRY: retry_cnt+1 and go to RESET_PLL.
REQ-024 On failure with retry_cnt==MAX_RETRY: go to FAULT.
REQ-025 On the edge entering RUN: sys_rst=0, ready=1, retry_cnt=0.
REQ-026 In RUN, lock_s=0 shall raise lock_loss_cnt (saturating at 255) and go to RESET_PLL.
REQ-027 In RUN, relock_req=1 shall go to RESET_PLL without changing lock_loss_cnt.
REQ-028 If lock_s=0 and relock_req=1 in the same RUN cycle, lock loss shall take priority: the counter increments once.
REQ-029 In FAULT: pll_reset=0, sys_rst=1, fault=1, ready=0.
REQ-030 FAULT shall be left only by relock_req, which clears retry_cnt and goes to RESET_PLL.
REQ-031 In every state except RUN: sys_rst=1 and ready=0.
REQ-032 fault=1 only in FAULT.
REQ-033 relock_req in RESET_PLL, WAIT_LOCK or FILTER shall be ignored.

Reset
REQ-034 While reset=1: state=RESET_PLL, pll_reset=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, all counters and synchronizer flops 0.
REQ-035 The RST_CYCLES count shall start on the first cycle with reset=0.
REQ-036 Reset asserted mid-operation, in any state, shall take effect on the next edge and reassert pll_reset and sys_rst.

Verification (RST_CYCLES=4, LOCK_FILTER=8, LOCK_TIMEOUT=64, MAX_RETRY=2)
REQ-037 Release reset; pll_lock=1 from cycle 6 -> pll_reset high cycles 0-3, low at 4; ready and sys_rst=0 at cycle 6+2+8 (±1, per RTL edge count, fixed in the bench); retry_cnt=0.
REQ-038 pll_lock held 0 -> three timeouts, each followed by a 4-cycle pll_reset pulse; retry_cnt steps 1, 2; FAULT (fault=1, sys_rst=1) after the third timeout; relock_req then returns to RESET_PLL with retry_cnt=0.
REQ-039 pll_lock toggling every 5 cycles -> never reaches RUN; attempt times out at 64 cycles; retry_cnt increments.
REQ-040 In RUN, drop pll_lock for 1 cycle -> 2 cycles later sys_rst=1, ready=0, lock_loss_cnt=1, pll_reset pulse of 4; a re-lock returns to RUN.
REQ-041 In RUN, pll_lock drop coincident (at lock_s) with relock_req -> lock_loss_cnt increments by exactly 1; 300 lock losses -> lock_loss_cnt=255.
REQ-042 reset asserted for 1 cycle while in FILTER -> next edge pll_reset=1, sys_rst=1, all counters 0.
